// File: rtl/overlap_discard_pkg.sv
// Shared overlap-save definitions: block size and the discard FSM state encoding.
package overlap_discard_pkg;

  // Samples per parallel block presented to the discard stage.
  localparam int unsigned BlockSize = 32;

  typedef enum logic {
    StIdle,   // buffer empty
    StStream  // buffer holds a block that is still being sent
  } state_e;

endpackage

// File: rtl/overlap_discard.sv
// Overlap-save discard stage. Accepts one 32-sample parallel block, drops the first
// N_OVERLAP samples and streams the remaining N_OUT samples out one per enabled cycle.
//
// Ports:
//   i_clk                 clock, rising edge
//   i_rst                 synchronous active-low reset
//   i_enable              global advance enable
//   i_valid               offered block on i_data_* is valid
//   i_data_0..i_data_31   parallel block, index 0 is the oldest sample
//   o_ready               (comb) offered block is accepted this cycle
//   o_valid               (reg) o_data carries a sample
//   o_data                (reg) serial output sample
//   o_overflow            (reg) one-cycle pulse when an offered block is dropped
module overlap_discard
  import overlap_discard_pkg::*;
#(
  parameter int unsigned NB_DATA   = 16,
  parameter int unsigned N_OVERLAP = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_0,
  input  logic [NB_DATA-1:0] i_data_1,
  input  logic [NB_DATA-1:0] i_data_2,
  input  logic [NB_DATA-1:0] i_data_3,
  input  logic [NB_DATA-1:0] i_data_4,
  input  logic [NB_DATA-1:0] i_data_5,
  input  logic [NB_DATA-1:0] i_data_6,
  input  logic [NB_DATA-1:0] i_data_7,
  input  logic [NB_DATA-1:0] i_data_8,
  input  logic [NB_DATA-1:0] i_data_9,
  input  logic [NB_DATA-1:0] i_data_10,
  input  logic [NB_DATA-1:0] i_data_11,
  input  logic [NB_DATA-1:0] i_data_12,
  input  logic [NB_DATA-1:0] i_data_13,
  input  logic [NB_DATA-1:0] i_data_14,
  input  logic [NB_DATA-1:0] i_data_15,
  input  logic [NB_DATA-1:0] i_data_16,
  input  logic [NB_DATA-1:0] i_data_17,
  input  logic [NB_DATA-1:0] i_data_18,
  input  logic [NB_DATA-1:0] i_data_19,
  input  logic [NB_DATA-1:0] i_data_20,
  input  logic [NB_DATA-1:0] i_data_21,
  input  logic [NB_DATA-1:0] i_data_22,
  input  logic [NB_DATA-1:0] i_data_23,
  input  logic [NB_DATA-1:0] i_data_24,
  input  logic [NB_DATA-1:0] i_data_25,
  input  logic [NB_DATA-1:0] i_data_26,
  input  logic [NB_DATA-1:0] i_data_27,
  input  logic [NB_DATA-1:0] i_data_28,
  input  logic [NB_DATA-1:0] i_data_29,
  input  logic [NB_DATA-1:0] i_data_30,
  input  logic [NB_DATA-1:0] i_data_31,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_overflow
);

  localparam int unsigned N_OUT = BlockSize - N_OVERLAP;
  // Keep the counter at least one bit wide when only one sample survives.
  localparam int unsigned CntW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_OUT - 1);

  logic [NB_DATA-1:0] blk [BlockSize];

  assign blk[0]  = i_data_0;
  assign blk[1]  = i_data_1;
  assign blk[2]  = i_data_2;
  assign blk[3]  = i_data_3;
  assign blk[4]  = i_data_4;
  assign blk[5]  = i_data_5;
  assign blk[6]  = i_data_6;
  assign blk[7]  = i_data_7;
  assign blk[8]  = i_data_8;
  assign blk[9]  = i_data_9;
  assign blk[10] = i_data_10;
  assign blk[11] = i_data_11;
  assign blk[12] = i_data_12;
  assign blk[13] = i_data_13;
  assign blk[14] = i_data_14;
  assign blk[15] = i_data_15;
  assign blk[16] = i_data_16;
  assign blk[17] = i_data_17;
  assign blk[18] = i_data_18;
  assign blk[19] = i_data_19;
  assign blk[20] = i_data_20;
  assign blk[21] = i_data_21;
  assign blk[22] = i_data_22;
  assign blk[23] = i_data_23;
  assign blk[24] = i_data_24;
  assign blk[25] = i_data_25;
  assign blk[26] = i_data_26;
  assign blk[27] = i_data_27;
  assign blk[28] = i_data_28;
  assign blk[29] = i_data_29;
  assign blk[30] = i_data_30;
  assign blk[31] = i_data_31;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [NB_DATA-1:0] buffer_q [N_OUT];

  logic last_sample;
  logic accept;

  assign last_sample = (state_q == StStream) && (cnt_q == CntLast);
  // Ready is also low during reset so nothing is handshaken while the block is held.
  assign o_ready     = i_rst & i_enable & ((state_q == StIdle) | last_sample);
  assign accept      = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      o_overflow <= i_valid & ~o_ready;
      o_valid    <= 1'b0;
      if (i_enable) begin
        if (state_q == StStream) begin
          o_data  <= buffer_q[cnt_q];
          o_valid <= 1'b1;
          if (last_sample) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A new block overrides the idle transition; o_data above still takes the old
        // last sample because the buffer read sees pre-edge contents.
        if (accept) begin
          for (int unsigned i = 0; i < N_OUT; i++) begin
            buffer_q[i] <= blk[N_OVERLAP + i];
          end
          cnt_q   <= '0;
          state_q <= StStream;
        end
      end
    end
  end

endmodule

// File: doc/overlap_discard.md
OVERLAP_DISCARD -- requirements
Module: overlap_discard

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 16, giving the sample width in bits (packed complex, 2x8).
REQ-002 The block SHALL have parameter N_OVERLAP, default 16, giving the number of leading block samples discarded; legal range 1..31.
REQ-003 The block SHALL have localparam N_OUT = 32 - N_OVERLAP, the number of samples emitted per block.
REQ-004 Port i_clk: input, 1 bit, the single clock; all logic on the rising edge.
REQ-005 Port i_rst: input, 1 bit, reset; synchronous and active-low.
REQ-006 Port i_enable: input, 1 bit, global advance enable.
REQ-007 Port i_valid: input, 1 bit, marks the current 32-sample block as valid.
REQ-008 Ports i_data_0 .. i_data_31: input, NB_DATA bits each, one parallel block; index 0 is the oldest sample.
REQ-009 Port o_ready: output, 1 bit, combinational; high when a block offered on i_valid is accepted this cycle.
REQ-010 Port o_valid: output, 1 bit, registered; marks a valid o_data sample.
REQ-011 Port o_data: output, NB_DATA bits, registered serial output sample.
REQ-012 Port o_overflow: output, 1 bit, registered; one-cycle pulse when an offered block is dropped.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (buffer empty) and STREAM (buffer holds an unsent block).
REQ-014 The block SHALL hold an N_OUT-entry buffer and a read counter cnt of width clog2(N_OUT).
REQ-015 o_ready SHALL equal i_enable AND (state==IDLE OR (state==STREAM AND cnt==N_OUT-1)).
REQ-016 On an edge with i_valid AND o_ready, the buffer SHALL load i_data_N_OVERLAP .. i_data_31 into entries 0..N_OUT-1, cnt SHALL go to 0, and state SHALL go to STREAM.
REQ-017 Samples i_data_0 .. i_data_(N_OVERLAP-1) SHALL never appear on o_data.
REQ-018 In STREAM with i_enable high, each edge SHALL register o_data <= buffer[cnt] and o_valid <= 1.
REQ-019 On that same edge, cnt SHALL increment by 1.
REQ-020 When the edge with cnt==N_OUT-1 has no accepted block, state SHALL go to IDLE and cnt SHALL go to 0.
REQ-021 Latency: a block accepted at edge k SHALL produce its first sample (o_valid=1) after edge k+1 and its last after edge k+N_OUT.
REQ-022 A block accepted on the last-sample edge SHALL stream back-to-back with no o_valid gap, while the old last sample is still output correctly.
REQ-023 In IDLE with no accepted block, each edge SHALL register o_valid <= 0; o_data SHALL hold its previous value.
REQ-024 With i_enable low, state, cnt, buffer and o_data SHALL hold, o_valid SHALL register 0, and o_ready SHALL be 0.
REQ-025 i_valid high with o_ready low SHALL leave state, cnt and buffer unchanged and SHALL register o_overflow <= 1 for one cycle; otherwise o_overflow registers 0.

Reset
REQ-026 With i_rst low at an edge, the block SHALL set o_valid=0, o_data=0, o_overflow=0, state=IDLE, cnt=0 and clear the buffer.
REQ-027 While i_rst is low, o_ready SHALL be 0.
REQ-028 Reset mid-STREAM SHALL discard the remaining buffered samples; no sample of that block SHALL appear after reset release.
REQ-029 Reset SHALL take priority over i_enable and i_valid.

Structure
REQ-030 State encodings (IDLE, STREAM) and the block size constant 32 SHALL live in the shared overlap-save package used with overlap_save.
REQ-031 The block SHALL be a single module with no sub-modules; the buffer SHALL be a register array, not a memory macro.

Verification
REQ-032 Reset, then a single block with i_data_k = k, N_OVERLAP=16: o_valid high for exactly 16 cycles starting 2 edges after i_valid, o_data = 16,17,..,31; samples 0..15 never seen.
REQ-033 Two blocks, values 100+k and 200+k, the second offered when o_ready rises at cnt=15: 32 contiguous o_valid cycles, o_data = 116..131 then 216..231.
REQ-034 Block offered at the 5th output cycle of a previous block: o_overflow pulses exactly once, the stream is undisturbed, and the dropped data never appears.
REQ-035 i_enable low for 3 cycles mid-stream after sample 20: o_valid=0 for 3 cycles, then the stream resumes at 21 with no loss or duplicate.
REQ-036 i_rst low for 1 cycle after sample 18 is output: o_valid=0, o_data=0, o_ready=1 after release, and samples 19..31 never appear.
REQ-037 N_OVERLAP=24, random block of 32 $random values: exactly 8 outputs, equal to i_data_24..i_data_31 in order.
